// File: rtl/fp_mul_round.sv
// Normalize and round-to-nearest-even stage for the single-precision multiplier.
// Two-entry valid/ready pipeline: s1 normalizes the raw product, s2 rounds and range-checks it.
module fp_mul_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf
);

  logic        s1_valid_reg;
  logic        s1_sign_reg;
  logic        s1_zero_reg;
  logic [9:0]  s1_exp_reg;
  logic [22:0] s1_frac_reg;
  logic        s1_guard_reg;
  logic        s1_sticky_reg;

  logic        s2_valid_reg;
  logic [31:0] s2_result_reg;
  logic        s2_ovf_reg;
  logic        s2_unf_reg;

  logic        s2_load;
  logic        s1_advance;
  logic        in_fire;

  logic [22:0] norm_frac;
  logic        norm_guard;
  logic        norm_sticky;
  logic [9:0]  norm_exp;

  logic        round_up;
  logic [23:0] frac_sum;
  logic [9:0]  rnd_exp;
  logic        rnd_ovf;
  logic        rnd_unf;
  logic [31:0] rnd_result;

  assign s2_load    = !s2_valid_reg || out_ready;
  assign s1_advance = s1_valid_reg && s2_load;
  assign in_ready   = !s1_valid_reg || s2_load;
  assign in_fire    = in_valid && in_ready;

  assign out_valid  = s2_valid_reg;
  assign out_result = s2_result_reg;
  assign out_ovf    = s2_ovf_reg;
  assign out_unf    = s2_unf_reg;

  // Leading one sits at bit 47 or 46; exponent is rebiased as a signed 10-bit value.
  always_comb begin
    norm_frac   = in_prod[45:23];
    norm_guard  = in_prod[22];
    norm_sticky = |in_prod[21:0];
    norm_exp    = {1'b0, in_exp} - 10'd127;
    if (in_prod[47]) begin
      norm_frac   = in_prod[46:24];
      norm_guard  = in_prod[23];
      norm_sticky = |in_prod[22:0];
      norm_exp    = {1'b0, in_exp} - 10'd126;
    end
  end

  // A rounding carry out of the fraction leaves frac_sum[22:0] at zero, so only exp moves.
  always_comb begin
    round_up   = s1_guard_reg && (s1_sticky_reg || s1_frac_reg[0]);
    frac_sum   = {1'b0, s1_frac_reg} + {23'd0, round_up};
    rnd_exp    = s1_exp_reg + {9'd0, frac_sum[23]};
    rnd_ovf    = 1'b0;
    rnd_unf    = 1'b0;
    rnd_result = {s1_sign_reg, rnd_exp[7:0], frac_sum[22:0]};
    if (s1_zero_reg) begin
      rnd_result = {s1_sign_reg, 31'd0};
    end else if ($signed(rnd_exp) >= 10'sd255) begin
      rnd_ovf    = 1'b1;
      rnd_result = {s1_sign_reg, 8'hFE, 23'h7FFFFF};
    end else if ($signed(rnd_exp) <= 10'sd0) begin
      rnd_unf    = 1'b1;
      rnd_result = {s1_sign_reg, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
      end else if (s1_advance) begin
        s1_valid_reg <= 1'b0;
      end
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_reg   <= in_sign;
      s1_zero_reg   <= in_zero;
      s1_exp_reg    <= norm_exp;
      s1_frac_reg   <= norm_frac;
      s1_guard_reg  <= norm_guard;
      s1_sticky_reg <= norm_sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_result_reg <= 32'd0;
      s2_ovf_reg    <= 1'b0;
      s2_unf_reg    <= 1'b0;
    end else if (s1_advance) begin
      s2_result_reg <= rnd_result;
      s2_ovf_reg    <= rnd_ovf;
      s2_unf_reg    <= rnd_unf;
    end
  end

endmodule

// File: tb/tb_fp_mul_round.sv
// Self-checking bench for fp_mul_round: scoreboard of expected {ovf,unf,result} per accepted input.
module tb_fp_mul_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [47:0] in_prod;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic        drv_has_exp;
  logic [33:0] drv_exp;

  fp_mul_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: shift the product down to a 24-bit mantissa and round on the remainder.
  function automatic logic [33:0] model(input logic s, input logic [8:0] e,
                                        input logic [47:0] p, input logic z);
    int          shift;
    int          ex;
    logic [47:0] mant;
    logic [47:0] rem;
    logic [47:0] half;
    logic [31:0] exv;
    shift = p[47] ? 24 : 23;
    ex    = int'(e) - (p[47] ? 126 : 127);
    mant  = p >> shift;
    rem   = p & ((48'd1 << shift) - 48'd1);
    half  = 48'd1 << (shift - 1);
    if (rem > half || (rem == half && mant[0])) mant = mant + 48'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      ex   = ex + 1;
    end
    exv = ex;
    if (z)             return {2'b00, s, 31'd0};
    else if (ex >= 255) return {2'b10, s, 8'hFE, 23'h7FFFFF};
    else if (ex <= 0)   return {2'b01, s, 31'd0};
    else                return {2'b00, s, exv[7:0], mant[22:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {63'd0, out_valid}, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        $display("out result=%h ovf=%b unf=%b (want %h)", out_result, out_ovf, out_unf, e);
        check_eq("result", {30'd0, out_ovf, out_unf, out_result}, {30'd0, e});
      end
    end
    if (rst_n && in_valid && in_ready)
      exp_q.push_back(drv_has_exp ? drv_exp : model(in_sign, in_exp, in_prod, in_zero));
  end

  // Returns #1 after the accepting edge.
  task automatic send(input logic s, input logic [8:0] e, input logic [47:0] p,
                      input logic z, input logic has_e, input logic [33:0] ev);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_prod = p; in_zero = z;
    drv_has_exp = has_e; drv_exp = ev;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [47:0] rand_prod();
    logic [47:0] p;
    p = {$urandom(), $urandom()};
    p[47] = $urandom_range(0, 1);
    if (!p[47]) p[46] = 1'b1;
    return p;
  endfunction

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0;
    in_zero = 1'b0; out_ready = 1'b1; drv_has_exp = 1'b0; drv_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_result", {30'd0, out_ovf, out_unf, out_result}, 64'd0);
    rst_n = 1'b1;

    // Normal product with latency check
    send(1'b0, 9'd254, 48'h900000000000, 1'b0, 1'b1, {2'b00, 32'h40100000});
    check_eq("lat_edge_k", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("lat_edge_k1", {63'd0, out_valid}, 64'd1);
    wait_drain();

    // Rounding ties, rounding carry, range and zero
    send(1'b0, 9'd254, 48'h400000400000, 1'b0, 1'b1, {2'b00, 32'h3F800000});
    send(1'b0, 9'd254, 48'h400000C00000, 1'b0, 1'b1, {2'b00, 32'h3F800002});
    send(1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0, 1'b1, {2'b00, 32'h40000000});
    send(1'b0, 9'd400, 48'h400000000000, 1'b0, 1'b1, {2'b10, 32'h7F7FFFFF});
    send(1'b1, 9'd100, 48'h400000000000, 1'b0, 1'b1, {2'b01, 32'h80000000});
    send(1'b1, 9'd300, 48'h900000000000, 1'b1, 1'b1, {2'b00, 32'h80000000});
    send(1'b1, 9'd400, 48'h400000000000, 1'b1, 1'b1, {2'b00, 32'h80000000});
    wait_drain();

    // Backpressure: 4 back-to-back with out_ready low for 3 cycles
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 9'd254, 48'h900000000000, 1'b0, 1'b1, {2'b00, 32'h40100000});
        send(1'b0, 9'd254, 48'h400000C00000, 1'b0, 1'b1, {2'b00, 32'h3F800002});
        send(1'b1, 9'd254, 48'h7FFFFFC00000, 1'b0, 1'b1, {2'b00, 32'hC0000000});
        send(1'b0, 9'd255, 48'h400000000000, 1'b0, 1'b1, {2'b00, 32'h40000000});
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        held = out_result;
        @(posedge clk);
        #1;
        check_eq("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check_eq("bp_hold", {32'd0, out_result}, {32'd0, held});
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_rise", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
          check_eq("bp_stream_valid", {63'd0, out_valid}, 64'd1);
          @(posedge clk);
          #1;
        end
      end
    join
    wait_drain();

    // Random stream with random backpressure
    fork
      for (int i = 0; i < 30; i++)
        send(1'($urandom_range(0, 1)), 9'($urandom_range(0, 510)), rand_prod(),
             ($urandom_range(0, 9) == 0), 1'b0, '0);
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset flush with both stages full
    out_ready = 1'b0;
    send(1'b0, 9'd254, 48'h900000000000, 1'b0, 1'b0, '0);
    send(1'b0, 9'd254, 48'h400000C00000, 1'b0, 1'b0, '0);
    check_eq("flush_full", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("flush_result", {30'd0, out_ovf, out_unf, out_result}, 64'd0);
    out_ready = 1'b1;
    send(1'b1, 9'd254, 48'h400000400000, 1'b0, 1'b1, {2'b00, 32'hBF800000});
    check_eq("post_flush_k", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("post_flush_k1", {63'd0, out_valid}, 64'd1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
